fpu_multiply_stage: RTL
=======================

Name: fpu_multiply_stage

Overview:
- Pipelined single-precision multiplier datapath. It sits directly upstream of the FPU rounding stage.
- Accepts two IEEE-754 binary32 operands plus a rounding mode, and produces an unrounded fpu_result_t: sign, biased exponent, 24-bit mantissa with hidden bit, 3-bit guard, mode, nan/inf/zero flags.
- The rounding stage consumes this result unchanged.
- Full throughput: one operation per cycle under valid/ready flow control.

Parameters:
- EXP_BIAS, 127, exponent bias used when summing operand exponents.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage accepts operands this cycle.
- in_a  in  32  binary32 operand A.
- in_b  in  32  binary32 operand B.
- in_mode  in  fpu_round_mode_t  rounding mode; passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream (rounding stage) accepts result.
- out_result  out  fpu_result_t  unrounded product.

Behaviour:
- Interface fixed: single clock clk; rst_n is asynchronous, active-low.
- Reset: all stage valid bits = 0, so out_valid = 0; out_result = all zeros; in_ready = 1 after reset release.
- Reset mid-operation discards every in-flight operation; nothing reaches the output afterwards.
- Handshake: transfer occurs when valid && ready. out_valid/out_result hold stable while out_valid && !out_ready.
- Three register stages S1 (classify), S2 (multiply), S3 (normalize/output).
- Stage k advances when its output register is empty or the next stage advances.
- in_ready = !S1.valid || S1 advances (combinational chain from out_ready).
- Latency: 3 cycles from input handshake to out_valid with no backpressure.
- Results are never lost or duplicated; order is preserved.
- S1 (classify):
  - sign = a[31]^b[31].
  - Operand with exp==0 is treated as zero (subnormals flushed); exp==255 with mant!=0 is NaN; exp==255 with mant==0 is Inf.
  - sig = {exp!=0, mant[22:0]}.
  - e = ea + eb − EXP_BIAS, computed as 10-bit signed.
- S2 (multiply): P[47:0] = sigA × sigB.
- S3 (normalize):
  - If P[47]: mantissa = P[47:24], guard = {P[23], P[22], |P[21:0]}, e += 1.
  - Else: mantissa = P[46:23], guard = {P[22], P[21], |P[20:0]}.
- Flags, priority order:
  - nan = any NaN operand, or Inf×zero.
  - inf = any Inf operand, or e ≥ 255.
  - zero = any zero operand, or e ≤ 0.
  - exponent = e[7:0] when no flag is set; otherwise 0 for zero, 255 for inf/nan.
- Only the highest-priority flag is set; the others are forced to 0. Sign is always sign.
- mode is carried through all stages with its operation.

Optional Feature:
- FPU_MULTIPLY_DSP_SPLIT_EN defined: S2 splits into two cycles.
  - Cycle 1: PP1 = sigA × sig_b[23:18].
  - Cycle 2: P = (PP1 << 18) + sigA × sig_b[17:0].
  - Latency becomes 4; throughput still 1/cycle; results bit-identical.
- Undefined: single-cycle 24×24 multiply, latency 3.

Decomposition:
- fpu package: fpu_result_t, fpu_round_mode_t, fpu_float_fields_t, and new constants FPU_EXP_BIAS = 127 and FPU_EXP_MAX = 255.
- Stage payload structs are local to the module.
- One natural sub-module: fpu_multiply_normalize. It is combinational S3 logic: P + e + class flags → fpu_result_t.

Test Plan:
- 0x3F800000 × 0x3FC00000 → after 3 cycles: sign 0, exp 127, mantissa 0xC00000, guard 000, no flags.
- 0x3FC00000 × 0x3FC00000 (2.25) → P[47] path: exp 128, mantissa 0x900000, guard 000.
- 0x3F800001 × 0x3F800001 → exp 127, mantissa 0x800002, guard 001 (sticky only); mode FPU_ROUND_MODE_UP passed through unchanged.
- Specials:
  - 0x7F800000 × 0x00000000 → nan=1.
  - 0xFF800000 × 0x3F800000 → inf=1, sign 1, exp 255.
  - 0x7FC00000 × 0x3F800000 → nan=1.
- Range:
  - 0x7F000000 × 0x7F000000 → inf=1.
  - 0x00800000 × 0x00800000 → zero=1, exp 0.
  - 0x00400000 (subnormal) × 0x3F800000 → zero=1.
- Flow control:
  - Stream 6 back-to-back ops with out_ready=0 for cycles 2–8 → in_ready drops once 3 held.
  - All 6 results emerge in order with no loss or duplication.
  - rst_n pulsed low mid-stream → out_valid=0 immediately (async); no stale results after release.

Source files
------------

// File: rtl/fpu_multiply_stage_pkg.sv
// fpu_multiply_stage_pkg: shared FPU types (rounding mode, binary32 fields, unrounded result) and exponent constants.
package fpu_multiply_stage_pkg;
  localparam int FPU_EXP_BIAS = 127;
  localparam int FPU_EXP_MAX = 255;
  typedef enum logic [2:0] {
    FPU_ROUND_MODE_RNE  = 3'd0,
    FPU_ROUND_MODE_RTZ  = 3'd1,
    FPU_ROUND_MODE_DOWN = 3'd2,
    FPU_ROUND_MODE_UP   = 3'd3,
    FPU_ROUND_MODE_RMM  = 3'd4
  } fpu_round_mode_t;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fpu_float_fields_t;
  typedef struct packed {
    logic            sign;
    logic [7:0]      exponent;
    logic [23:0]     mantissa;
    logic [2:0]      guard;
    fpu_round_mode_t mode;
    logic            nan;
    logic            inf;
    logic            zero;
  } fpu_result_t;
endpackage

// File: rtl/fpu_multiply_normalize.sv
// fpu_multiply_normalize: combinational normalize of a 48-bit significand product into an unrounded result.
// Ports: p product, e biased exponent sum (signed), sign, nan_c/inf_c/zero_c operand classes, mode, res result.
module fpu_multiply_normalize
  import fpu_multiply_stage_pkg::*;
(
  input  logic [47:0]       p,
  input  logic signed [9:0] e,
  input  logic              sign,
  input  logic              nan_c,
  input  logic              inf_c,
  input  logic              zero_c,
  input  fpu_round_mode_t   mode,
  output fpu_result_t       res
);
  logic signed [9:0] e_n;
  logic inf, zero;
  always_comb begin
    e_n = p[47] ? e + 10'sd1 : e;
    inf = !nan_c && (inf_c || e_n >= FPU_EXP_MAX);
    zero = !nan_c && !inf && (zero_c || e_n <= 0);
    res.sign = sign;
    res.mantissa = p[47] ? p[47:24] : p[46:23];
    res.guard = p[47] ? {p[23], p[22], |p[21:0]} : {p[22], p[21], |p[20:0]};
    res.mode = mode;
    res.nan = nan_c;
    res.inf = inf;
    res.zero = zero;
    res.exponent = zero ? 8'd0 : (nan_c || inf) ? 8'd255 : e_n[7:0];
  end
endmodule

// File: rtl/fpu_multiply_stage.sv
// fpu_multiply_stage: pipelined binary32 multiplier (classify, multiply, normalize) with valid/ready flow control.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_a/in_b/in_mode operand side,
// out_valid/out_ready/out_result unrounded product side.
// FPU_MULTIPLY_DSP_SPLIT_EN: splits the multiply into two cycles (latency 4 instead of 3).
module fpu_multiply_stage
  import fpu_multiply_stage_pkg::*;
#(
  parameter int EXP_BIAS = FPU_EXP_BIAS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  fpu_round_mode_t in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output fpu_result_t     out_result
);
  typedef struct packed {
    logic            sign;
    logic [9:0]      e;
    logic            nan;
    logic            inf;
    logic            zero;
    fpu_round_mode_t mode;
  } meta_t;
  typedef struct packed {
    meta_t       m;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
  } s1_t;
  typedef struct packed {
    meta_t       m;
    logic [47:0] p;
  } s2_t;
  fpu_float_fields_t fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic rdy1, rdy2, rdy3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t s1_in, s1_q, s1_d;
  s2_t s2_in, s2_q, s2_d;
  fpu_result_t norm, s3_q, s3_d;
`ifdef FPU_MULTIPLY_DSP_SPLIT_EN
  typedef struct packed {
    meta_t       m;
    logic [23:0] sig_a;
    logic [17:0] sig_b_lo;
    logic [29:0] pp1;
  } s2a_t;
  logic rdy2a, v2a_q, v2a_d;
  s2a_t s2a_in, s2a_q, s2a_d;
`endif
  always_comb begin
    fa = fpu_float_fields_t'(in_a);
    fb = fpu_float_fields_t'(in_b);
    a_zero = fa.exp == 8'd0;
    a_inf = &fa.exp && fa.mant == 23'd0;
    a_nan = &fa.exp && fa.mant != 23'd0;
    b_zero = fb.exp == 8'd0;
    b_inf = &fb.exp && fb.mant == 23'd0;
    b_nan = &fb.exp && fb.mant != 23'd0;
    rdy3 = !v3_q || out_ready;
    rdy2 = !v2_q || rdy3;
`ifdef FPU_MULTIPLY_DSP_SPLIT_EN
    rdy2a = !v2a_q || rdy2;
    rdy1 = !v1_q || rdy2a;
`else
    rdy1 = !v1_q || rdy2;
`endif
    in_ready = rdy1;
    s1_in.m.sign = fa.sign ^ fb.sign;
    s1_in.m.e = 10'(fa.exp) + 10'(fb.exp) - 10'(EXP_BIAS);
    s1_in.m.nan = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    s1_in.m.inf = a_inf || b_inf;
    s1_in.m.zero = a_zero || b_zero;
    s1_in.m.mode = in_mode;
    s1_in.sig_a = {!a_zero, fa.mant};
    s1_in.sig_b = {!b_zero, fb.mant};
    v1_d = rdy1 ? in_valid : v1_q;
    s1_d = (rdy1 && in_valid) ? s1_in : s1_q;
`ifdef FPU_MULTIPLY_DSP_SPLIT_EN
    s2a_in.m = s1_q.m;
    s2a_in.sig_a = s1_q.sig_a;
    s2a_in.sig_b_lo = s1_q.sig_b[17:0];
    s2a_in.pp1 = 30'(s1_q.sig_a) * 30'(s1_q.sig_b[23:18]);
    v2a_d = rdy2a ? v1_q : v2a_q;
    s2a_d = (rdy2a && v1_q) ? s2a_in : s2a_q;
    s2_in.m = s2a_q.m;
    s2_in.p = (48'(s2a_q.pp1) << 18) + 48'(s2a_q.sig_a) * 48'(s2a_q.sig_b_lo);
    v2_d = rdy2 ? v2a_q : v2_q;
    s2_d = (rdy2 && v2a_q) ? s2_in : s2_q;
`else
    s2_in.m = s1_q.m;
    s2_in.p = 48'(s1_q.sig_a) * 48'(s1_q.sig_b);
    v2_d = rdy2 ? v1_q : v2_q;
    s2_d = (rdy2 && v1_q) ? s2_in : s2_q;
`endif
    v3_d = rdy3 ? v2_q : v3_q;
    s3_d = (rdy3 && v2_q) ? norm : s3_q;
  end
  fpu_multiply_normalize u_norm (
    .p(s2_q.p),
    .e(s2_q.m.e),
    .sign(s2_q.m.sign),
    .nan_c(s2_q.m.nan),
    .inf_c(s2_q.m.inf),
    .zero_c(s2_q.m.zero),
    .mode(s2_q.m.mode),
    .res(norm)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
`ifdef FPU_MULTIPLY_DSP_SPLIT_EN
      v2a_q <= 1'b0;
      s2a_q <= '0;
`endif
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
`ifdef FPU_MULTIPLY_DSP_SPLIT_EN
      v2a_q <= v2a_d;
      s2a_q <= s2a_d;
`endif
    end
  end
  assign out_valid = v3_q;
  assign out_result = s3_q;
endmodule
